nv_nvdla_pdp_wdma_dat_fifo_ctrl: RTL and testbench



---
 rtl/nv_nvdla_pdp_wdma_dat_fifo_ctrl.sv | 71 +++++++
 tb/tb_nv_nvdla_pdp_wdma_dat_fifo_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_pdp_wdma_dat_fifo_ctrl.sv
// rtl/nv_nvdla_pdp_wdma_dat_fifo_ctrl.sv - control and registered read-out for the PDP WDMA 3x64 flop-RAM FIFO
module nv_nvdla_pdp_wdma_dat_fifo_ctrl (
  input  logic        clk,
  input  logic        reset_,
  input  logic        wr_pvld,
  output logic        wr_prdy,
  input  logic [63:0] wr_pd,
  output logic        rd_pvld,
  input  logic        rd_prdy,
  output logic [63:0] rd_pd,
  output logic        ram_we,
  output logic [1:0]  ram_wa,
  output logic [63:0] ram_di,
  output logic [1:0]  ram_ra,
  input  logic [63:0] ram_dout,
  output logic [2:0]  wr_count,
  output logic        fifo_idle
);

  logic [1:0] wr_adr;
  logic [1:0] rd_adr;
  logic [1:0] ram_cnt;
  logic       wr_acc;
  logic       out_free;
  logic       byp;
  logic       rd_ld;

  function automatic logic [1:0] adr_inc(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  assign wr_prdy  = (ram_cnt != 2'd3);
  assign wr_acc   = wr_pvld & wr_prdy;
  assign out_free = ~rd_pvld | rd_prdy;

  // byp and rd_ld are mutually exclusive: one needs an empty RAM, the other a non-empty one
  assign byp    = wr_acc & (ram_cnt == 2'd0) & out_free;
  assign rd_ld  = out_free & (ram_cnt != 2'd0);
  assign ram_we = wr_acc & ~byp;
  assign ram_wa = wr_adr;
  assign ram_di = wr_pd;
  assign ram_ra = byp ? 2'd3 : rd_adr;

  assign wr_count  = {1'b0, ram_cnt} + {2'b00, rd_pvld};
  assign fifo_idle = (wr_count == 3'd0);

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_adr  <= 2'd0;
      rd_adr  <= 2'd0;
      ram_cnt <= 2'd0;
      rd_pvld <= 1'b0;
      rd_pd   <= 64'd0;
    end else begin
      if (ram_we) wr_adr <= adr_inc(wr_adr);
      if (rd_ld)  rd_adr <= adr_inc(rd_adr);
      case ({ram_we, rd_ld})
        2'b10:   ram_cnt <= ram_cnt + 2'd1;
        2'b01:   ram_cnt <= ram_cnt - 2'd1;
        default: ram_cnt <= ram_cnt;
      endcase
      if (byp | rd_ld) begin
        rd_pd   <= ram_dout;
        rd_pvld <= 1'b1;
      end else if (out_free) begin
        rd_pvld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_wdma_dat_fifo_ctrl.sv
// tb/tb_nv_nvdla_pdp_wdma_dat_fifo_ctrl.sv - scoreboard bench with a 3-entry flop RAM model
module tb_nv_nvdla_pdp_wdma_dat_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset_;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [63:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [63:0] rd_pd;
  logic        ram_we;
  logic [1:0]  ram_wa;
  logic [63:0] ram_di;
  logic [1:0]  ram_ra;
  logic [63:0] ram_dout;
  logic [2:0]  wr_count;
  logic        fifo_idle;

  logic [63:0] mem [3];
  logic [63:0] q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          wseq = 0;
  bit          started = 0;

  always #5 clk = ~clk;

  nv_nvdla_pdp_wdma_dat_fifo_ctrl dut (
    .clk(clk), .reset_(reset_),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_dout(ram_dout),
    .wr_count(wr_count), .fifo_idle(fifo_idle)
  );

  // External flop RAM: synchronous write, combinational read, address 3 passes ram_di through
  always @(posedge clk) if (ram_we && ram_wa != 2'd3) mem[ram_wa] <= ram_di;
  assign ram_dout = (ram_ra == 2'd3) ? ram_di : mem[ram_ra];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the FIFO content is just an ordered queue of accepted words
  always @(negedge clk) begin
    if (!reset_) begin
      q.delete();
      wseq = 0;
      started = 1;
    end else if (started) begin
      chk("wr_count", {61'd0, wr_count}, 64'(q.size()));
      chk("fifo_idle", {63'd0, fifo_idle}, {63'd0, q.size() == 0});
      chk("wr_prdy", {63'd0, wr_prdy}, {63'd0, q.size() < 4});
      chk("rd_pvld", {63'd0, rd_pvld}, {63'd0, q.size() > 0});
      if (q.size() > 0) chk("rd_pd", rd_pd, q[0]);
      if (ram_we) begin
        chk("ram_wa_seq", {62'd0, ram_wa}, 64'(wseq));
        wseq = (wseq + 1) % 3;
      end
      if (rd_pvld && rd_prdy && q.size() > 0) void'(q.pop_front());
      if (wr_pvld && wr_prdy) q.push_back(wr_pd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    bit acc = 0;
    wr_pvld = 1'b1;
    wr_pd   = v;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = wr_prdy;
      step();
    end
    wr_pvld = 1'b0;
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    reset_ = 1'b0; wr_pvld = 1'b1; wr_pd = 64'h1234; rd_prdy = 1'b0;
    step();
    @(negedge clk);
    chk("rst_wr_prdy", {63'd0, wr_prdy}, 64'd1);
    chk("rst_rd_pvld", {63'd0, rd_pvld}, 64'd0);
    chk("rst_rd_pd", rd_pd, 64'd0);
    chk("rst_wr_count", {61'd0, wr_count}, 64'd0);
    chk("rst_ram_we", {63'd0, ram_we}, 64'd0);
    step();
    reset_ = 1'b1; wr_pvld = 1'b0;
    @(negedge clk);
    chk("rst_ram_ra", {62'd0, ram_ra}, 64'd0);
    chk("rst_ram_wa", {62'd0, ram_wa}, 64'd0);
    chk("rst_idle", {63'd0, fifo_idle}, 64'd1);
    step();

    // Bypass into the empty FIFO
    rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 64'hA5A5_0000_0000_0001;
    @(negedge clk);
    chk("byp_ram_ra", {62'd0, ram_ra}, 64'd3);
    chk("byp_ram_we", {63'd0, ram_we}, 64'd0);
    step();
    wr_pvld = 1'b0;
    @(negedge clk);
    chk("byp_rd_pd", rd_pd, 64'hA5A5_0000_0000_0001);
    chk("byp_count", {61'd0, wr_count}, 64'd1);
    step();
    step();

    // Fill with the output held off
    rd_prdy = 1'b0;
    for (int i = 1; i <= 4; i++) push(64'(i));
    wr_pvld = 1'b1; wr_pd = 64'h5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_count", {61'd0, wr_count}, 64'd4);
      chk("full_wr_prdy", {63'd0, wr_prdy}, 64'd0);
      step();
    end

    // Drain from full while continuing to write; addresses wrap
    rd_prdy = 1'b1;
    for (int i = 5; i <= 8; i++) push(64'(i));
    repeat (6) step();
    chk("drained", {61'd0, wr_count}, 64'd0);

    // Random writes against random backpressure
    for (int i = 0; i < 300; i++) begin
      wr_pvld = 1'($urandom_range(0, 1));
      wr_pd   = {$urandom, $urandom};
      rd_prdy = 1'($urandom_range(0, 1));
      step();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    repeat (6) step();

    // Reset with three words in flight
    rd_prdy = 1'b0;
    for (int i = 0; i < 3; i++) push(64'h100 + 64'(i));
    @(negedge clk);
    chk("pre_rst_count", {61'd0, wr_count}, 64'd3);
    reset_ = 1'b0;
    step();
    reset_ = 1'b1;
    @(negedge clk);
    chk("mid_rst_count", {61'd0, wr_count}, 64'd0);
    chk("mid_rst_pvld", {63'd0, rd_pvld}, 64'd0);
    rd_prdy = 1'b1;
    push(64'hDEAD);
    @(negedge clk);
    chk("dead_pvld", {63'd0, rd_pvld}, 64'd1);
    chk("dead_pd", rd_pd, 64'hDEAD);
    step();

    for (int i = 0; i < 200; i++) begin
      wr_pvld = 1'($urandom_range(0, 1));
      wr_pd   = {$urandom, $urandom};
      rd_prdy = ($urandom_range(0, 3) != 0);
      step();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    repeat (6) step();
    chk("final_idle", {63'd0, fifo_idle}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
